// File: rtl/syn_fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one synchronous FIFO write port among
// NUM_REQ producers, granting one owner at a time for up to BURST_LEN beats.
//
// state | meaning
// IDLE  | no grant held; pick next requester round-robin from last_owner+1
// GRANT | gnt_id owns the write port; beats forwarded while FIFO not full
module syn_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
  output logic                          busy
);

  localparam int GNT_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [GNT_W-1:0] LAST_IDX  = GNT_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_q, state_d;
  logic [GNT_W-1:0]      gnt_d, last_owner, last_d, rr_sel, rr_idx;
  logic [CNT_W-1:0]      beat_cnt, cnt_d;
  logic                  rr_found, owner_valid, xfer;
  logic [DATA_WIDTH-1:0] owner_data;

  assign busy = (state_q == GRANT);
  assign xfer = busy & owner_valid & ~fifo_full;

  // Round-robin search: first valid requester starting just after last_owner.
  always_comb begin
    rr_sel   = last_owner;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = GNT_W'((int'(last_owner) + k) % NUM_REQ);
      if (!rr_found && req_valid[rr_idx]) begin
        rr_sel   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  // Select the current owner's valid and data lanes.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GNT_W'(i) == gnt_id) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic; a dropped owner valid releases even while the FIFO is full.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_id;
    last_d  = last_owner;
    cnt_d   = beat_cnt;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d = GRANT;
          gnt_d   = rr_sel;
          last_d  = rr_sel;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!owner_valid) begin
          state_d = IDLE;
        end else if (xfer) begin
          cnt_d = beat_cnt + 1'b1;
          if (beat_cnt == LAST_BEAT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset points last_owner at the top so requester 0 wins first.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      gnt_id     <= '0;
      last_owner <= LAST_IDX;
      beat_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_id     <= gnt_d;
      last_owner <= last_d;
      beat_cnt   <= cnt_d;
    end
  end

  // Only the owner is ever ready, and only while the FIFO has room.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = busy & (GNT_W'(i) == gnt_id) & ~fifo_full;
    end
  end

  assign fifo_wr_en   = xfer;
  assign fifo_wr_data = busy ? owner_data : '0;

endmodule
